fpq_level_ctrl: RTL and testbench
=================================

FPQ_LEVEL_CTRL -- requirements
Module: fpq_level_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 50000, means clk cycles per timebase tick (>=2).
REQ-002 Parameter HOLD_TICKS, default 50, means ticks the peak is held before decay starts (>=1).
REQ-003 Parameter DECAY_TICKS, default 4, means ticks between successive decay steps (>=1).
REQ-004 clk  input  1  means the single system clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  means the reset: asynchronous and active-low.
REQ-006 sample_in  input  8  means the unsigned level sample.
REQ-007 sample_valid  input  1  means sample_in is valid this cycle (single-cycle strobe).
REQ-008 clear  input  1  means the synchronous clear of all level state.
REQ-009 cur_value  output  8  means the displayed level, fed to the LED bar decoder.
REQ-010 peak_value  output  8  means the maximum accepted sample since reset/clear.
REQ-011 state_o  output  2  means the FSM state: 00 IDLE, 01 HOLD, 10 DECAY.

Function
REQ-012 The tick counter SHALL count 0..TICK_DIV-1 and wrap, asserting an internal tick for the one cycle where count == TICK_DIV-1.
REQ-013 A sample SHALL be accepted when sample_valid=1, sample_in!=0, and sample_in>=cur_value.
REQ-014 On acceptance, cur_value SHALL equal sample_in on the next clock edge (1-cycle latency), state SHALL become HOLD, and the hold counter SHALL clear to 0.
REQ-015 Samples with sample_in<cur_value, or sample_in==0, SHALL be ignored, with no state change.
REQ-016 peak_value SHALL load sample_in on any valid sample with sample_in>peak_value, regardless of state; it never decays.
REQ-017 IDLE: cur_value==0; the FSM SHALL leave IDLE only by acceptance (REQ-014).
REQ-018 HOLD: each tick SHALL increment the hold counter; a tick with the hold counter == HOLD_TICKS-1 SHALL move to DECAY and clear the decay counter.
REQ-019 DECAY: each tick SHALL increment the decay counter; a tick with the decay counter == DECAY_TICKS-1 SHALL set cur_value to cur_value>>1 (one LED step) and clear the decay counter.
REQ-020 A decay step producing cur_value==0 SHALL move the FSM to IDLE in the same edge.
REQ-021 Acceptance in the same cycle as a tick SHALL take priority: the tick's hold/decay action is discarded and REQ-014 applies.
REQ-022 clear=1 SHALL take priority over sample and tick on that edge: cur_value=0, peak_value=0, state IDLE, and tick/hold/decay counters=0.
REQ-023 The FSM SHALL hold no unused state; the encoding 11 SHALL recover to IDLE with cur_value=0 on the next edge.
REQ-024 Counter widths SHALL be sized by $clog2 of their parameter; no counter may wrap other than as specified.

Reset
REQ-025 rst_n=0 SHALL immediately force cur_value=0, peak_value=0, state_o=00, and all counters=0, independent of clk.
REQ-026 Reset deassertion SHALL be followed by normal operation from the first rising clk edge; a reset mid-HOLD/DECAY SHALL discard all progress.

Verification (TICK_DIV=4, HOLD_TICKS=2, DECAY_TICKS=1)
REQ-027 Reset check: assert rst_n=0 mid-DECAY with cur_value=8'h30 -> outputs are 0 and state_o=00 before the next clk edge.
REQ-028 Attack/hold/decay: a single sample 8'hC8 -> cur_value=C8 one cycle later, state HOLD; after 2 ticks state DECAY; subsequent ticks give 64, 32, 19, 0C, 06, 03, 01, 00, then IDLE.
REQ-029 Ignore/restart: in HOLD at 8'h40, sample 8'h20 -> no change; sample 8'h40 -> hold counter restarts and DECAY is delayed by 2 full ticks from that sample.
REQ-030 Collision: sample 8'h50 on the same cycle as a decay tick with cur_value=8'h30 -> cur_value=50, state HOLD, and no shift applied.
REQ-031 Clear priority: clear=1 together with sample_valid, sample 8'hFF -> cur_value=0, peak_value=0, state IDLE.
REQ-032 Peak tracking: samples 10, 80, 20 spaced by a full decay to IDLE -> peak_value ends at 8'h80 while cur_value returns to 0.

Source files
------------

// File: rtl/fpq_level_ctrl.sv
// fpq_level_ctrl -- peak-hold level meter controller for an LED bar display.
//
// A free-running timebase divides clk into ticks. A valid non-zero sample that
// is at least the displayed level is accepted: the display jumps to it and is
// held for HOLD_TICKS ticks. It then decays by one LED step (a right shift)
// every DECAY_TICKS ticks until it reaches zero. A separate peak register
// remembers the largest sample seen since reset or clear.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   sample_in    in   [7:0] unsigned level sample
//   sample_valid in   single-cycle strobe qualifying sample_in
//   clear        in   synchronous clear of all level state
//   cur_value    out  [7:0] displayed level (to LED bar decoder)
//   peak_value   out  [7:0] maximum valid sample since reset/clear
//   state_o      out  [1:0] FSM state: 00 IDLE, 01 HOLD, 10 DECAY
module fpq_level_ctrl #(
    parameter int TICK_DIV    = 50000,
    parameter int HOLD_TICKS  = 50,
    parameter int DECAY_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sample_in,
    input  logic       sample_valid,
    input  logic       clear,
    output logic [7:0] cur_value,
    output logic [7:0] peak_value,
    output logic [1:0] state_o
);

    // A parameter of 1 would give a zero-width counter; keep at least one bit.
    localparam int TW = (TICK_DIV    > 1) ? $clog2(TICK_DIV)    : 1;
    localparam int HW = (HOLD_TICKS  > 1) ? $clog2(HOLD_TICKS)  : 1;
    localparam int DW = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_HOLD  = 2'b01,
        S_DECAY = 2'b10
    } state_t;

    state_t          r_state;
    state_t          w_nxt_state;
    logic [7:0]      r_cur,       w_nxt_cur;
    logic [7:0]      r_peak,      w_nxt_peak;
    logic [TW-1:0]   r_tick_cnt,  w_nxt_tick_cnt;
    logic [HW-1:0]   r_hold_cnt,  w_nxt_hold_cnt;
    logic [DW-1:0]   r_decay_cnt, w_nxt_decay_cnt;
    logic            w_tick;
    logic            w_accept;
    logic [7:0]      w_half;

    assign w_tick   = (r_tick_cnt == TW'(TICK_DIV - 1));
    assign w_accept = sample_valid && (sample_in != 8'd0) && (sample_in >= r_cur);
    assign w_half   = {1'b0, r_cur[7:1]};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    // Next-state and datapath decisions. Priority: clear, illegal-state
    // recovery, acceptance, then tick-driven hold/decay progress.
    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_cur       = r_cur;
        w_nxt_peak      = r_peak;
        w_nxt_hold_cnt  = r_hold_cnt;
        w_nxt_decay_cnt = r_decay_cnt;
        w_nxt_tick_cnt  = w_tick ? '0 : r_tick_cnt + TW'(1);

        // Peak tracks every valid sample, even ones the display ignores.
        if (sample_valid && (sample_in > r_peak)) begin
            w_nxt_peak = sample_in;
        end

        if (clear) begin
            w_nxt_state     = S_IDLE;
            w_nxt_cur       = 8'd0;
            w_nxt_peak      = 8'd0;
            w_nxt_tick_cnt  = '0;
            w_nxt_hold_cnt  = '0;
            w_nxt_decay_cnt = '0;
        end else begin
            case (r_state)
                S_IDLE, S_HOLD, S_DECAY: begin
                    if (w_accept) begin
                        // Acceptance wins over a coincident tick.
                        w_nxt_state    = S_HOLD;
                        w_nxt_cur      = sample_in;
                        w_nxt_hold_cnt = '0;
                    end else if (w_tick) begin
                        case (r_state)
                            S_HOLD: begin
                                if (r_hold_cnt == HW'(HOLD_TICKS - 1)) begin
                                    w_nxt_state     = S_DECAY;
                                    w_nxt_decay_cnt = '0;
                                end else begin
                                    w_nxt_hold_cnt = r_hold_cnt + HW'(1);
                                end
                            end
                            S_DECAY: begin
                                if (r_decay_cnt == DW'(DECAY_TICKS - 1)) begin
                                    w_nxt_cur       = w_half;
                                    w_nxt_decay_cnt = '0;
                                    if (w_half == 8'd0) begin
                                        w_nxt_state = S_IDLE;
                                    end
                                end else begin
                                    w_nxt_decay_cnt = r_decay_cnt + DW'(1);
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                default: begin
                    // Encoding 11 is unreachable; fall back to a blank display.
                    w_nxt_state     = S_IDLE;
                    w_nxt_cur       = 8'd0;
                    w_nxt_hold_cnt  = '0;
                    w_nxt_decay_cnt = '0;
                end
            endcase
        end
    end

    // Level, peak and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur       <= 8'd0;
            r_peak      <= 8'd0;
            r_tick_cnt  <= '0;
            r_hold_cnt  <= '0;
            r_decay_cnt <= '0;
        end else begin
            r_cur       <= w_nxt_cur;
            r_peak      <= w_nxt_peak;
            r_tick_cnt  <= w_nxt_tick_cnt;
            r_hold_cnt  <= w_nxt_hold_cnt;
            r_decay_cnt <= w_nxt_decay_cnt;
        end
    end

    assign cur_value  = r_cur;
    assign peak_value = r_peak;
    assign state_o    = r_state;

endmodule

// File: tb/tb_fpq_level_ctrl.sv
// Directed bench for fpq_level_ctrl with TICK_DIV=4, HOLD_TICKS=2,
// DECAY_TICKS=1. tb_phase follows the timebase counter value after each edge
// so that ticks (the edge taken while the counter sits at 3) can be targeted.
module tb_fpq_level_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] sample_in = 8'd0;
    logic       sample_valid = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] cur_value;
    logic [7:0] peak_value;
    logic [1:0] state_o;

    int total = 0;
    int bad   = 0;
    int tb_phase = 0;
    logic [7:0] dseq [0:7];

    fpq_level_ctrl #(
        .TICK_DIV   (4),
        .HOLD_TICKS (2),
        .DECAY_TICKS(1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_in   (sample_in),
        .sample_valid(sample_valid),
        .clear       (clear),
        .cur_value   (cur_value),
        .peak_value  (peak_value),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
        tb_phase = (tb_phase == 3) ? 0 : tb_phase + 1;
    endtask

    task automatic tick_step();
        while (tb_phase != 3) step();
        step();
    endtask

    task automatic send(input logic [7:0] v);
        sample_in    = v;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        sample_in    = 8'd0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tb_phase = 0;
    endtask

    task automatic run_to_idle(input string name);
        for (int i = 0; i < 200 && state_o !== 2'b00; i++) step();
        total++;
        if (state_o !== 2'b00) begin
            bad++;
            $display("FAIL %s_idle_timeout state=%b exp=00", name, state_o);
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (cur_value !== 8'h00) begin bad++; $display("FAIL rst_cur got=%h exp=00", cur_value); end
        total++; if (peak_value !== 8'h00) begin bad++; $display("FAIL rst_peak got=%h exp=00", peak_value); end
        total++; if (state_o !== 2'b00) begin bad++; $display("FAIL rst_state got=%b exp=00", state_o); end
        // Reach DECAY with 0x30 displayed, then reset between clock edges.
        send(8'h30);
        tick_step();
        tick_step();
        total++; if (state_o !== 2'b10) begin bad++; $display("FAIL rst_pre_decay got=%b exp=10", state_o); end
        total++; if (cur_value !== 8'h30) begin bad++; $display("FAIL rst_pre_cur got=%h exp=30", cur_value); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (cur_value !== 8'h00) begin bad++; $display("FAIL rst_async_cur got=%h exp=00", cur_value); end
        total++; if (peak_value !== 8'h00) begin bad++; $display("FAIL rst_async_peak got=%h exp=00", peak_value); end
        total++; if (state_o !== 2'b00) begin bad++; $display("FAIL rst_async_state got=%b exp=00", state_o); end
        #1;
        rst_n = 1'b1;
        tb_phase = 0;
        send(8'h05);
        total++; if (cur_value !== 8'h05) begin bad++; $display("FAIL rst_resume_cur got=%h exp=05", cur_value); end
        total++; if (state_o !== 2'b01) begin bad++; $display("FAIL rst_resume_state got=%b exp=01", state_o); end
    endtask

    task automatic test_attack_decay();
        dseq[0] = 8'h64; dseq[1] = 8'h32; dseq[2] = 8'h19; dseq[3] = 8'h0C;
        dseq[4] = 8'h06; dseq[5] = 8'h03; dseq[6] = 8'h01; dseq[7] = 8'h00;
        do_reset();
        send(8'hC8);
        total++; if (cur_value !== 8'hC8) begin bad++; $display("FAIL atk_cur got=%h exp=C8", cur_value); end
        total++; if (state_o !== 2'b01) begin bad++; $display("FAIL atk_state got=%b exp=01", state_o); end
        total++; if (peak_value !== 8'hC8) begin bad++; $display("FAIL atk_peak got=%h exp=C8", peak_value); end
        tick_step();
        total++; if (state_o !== 2'b01) begin bad++; $display("FAIL atk_hold1 got=%b exp=01", state_o); end
        tick_step();
        total++; if (state_o !== 2'b10) begin bad++; $display("FAIL atk_decay got=%b exp=10", state_o); end
        total++; if (cur_value !== 8'hC8) begin bad++; $display("FAIL atk_decay_cur got=%h exp=C8", cur_value); end
        for (int k = 0; k < 8; k++) begin
            tick_step();
            total++;
            if (cur_value !== dseq[k]) begin
                bad++; $display("FAIL atk_step%0d got=%h exp=%h", k, cur_value, dseq[k]);
            end
            total++;
            if (state_o !== ((k == 7) ? 2'b00 : 2'b10)) begin
                bad++; $display("FAIL atk_step%0d_state got=%b exp=%b", k, state_o, (k == 7) ? 2'b00 : 2'b10);
            end
        end
        total++; if (peak_value !== 8'hC8) begin bad++; $display("FAIL atk_peak_kept got=%h exp=C8", peak_value); end
    endtask

    task automatic test_ignore_restart();
        do_reset();
        send(8'h40);
        tick_step();
        send(8'h20);
        total++; if (cur_value !== 8'h40) begin bad++; $display("FAIL ign_cur got=%h exp=40", cur_value); end
        total++; if (state_o !== 2'b01) begin bad++; $display("FAIL ign_state got=%b exp=01", state_o); end
        send(8'h00);
        total++; if (cur_value !== 8'h40) begin bad++; $display("FAIL ign_zero got=%h exp=40", cur_value); end
        send(8'h40);
        tick_step();
        total++; if (state_o !== 2'b01) begin bad++; $display("FAIL rst_hold_t1 got=%b exp=01", state_o); end
        tick_step();
        total++; if (state_o !== 2'b10) begin bad++; $display("FAIL rst_hold_t2 got=%b exp=10", state_o); end
        total++; if (cur_value !== 8'h40) begin bad++; $display("FAIL rst_hold_cur got=%h exp=40", cur_value); end
    endtask

    task automatic test_collision();
        do_reset();
        send(8'h30);
        tick_step();
        tick_step();
        total++; if (state_o !== 2'b10) begin bad++; $display("FAIL col_pre got=%b exp=10", state_o); end
        while (tb_phase != 3) step();
        send(8'h50);
        total++; if (cur_value !== 8'h50) begin bad++; $display("FAIL col_cur got=%h exp=50", cur_value); end
        total++; if (state_o !== 2'b01) begin bad++; $display("FAIL col_state got=%b exp=01", state_o); end
        tick_step();
        total++; if (state_o !== 2'b01) begin bad++; $display("FAIL col_hold got=%b exp=01", state_o); end
        total++; if (cur_value !== 8'h50) begin bad++; $display("FAIL col_hold_cur got=%h exp=50", cur_value); end
    endtask

    task automatic test_clear();
        // Continues from the HOLD state left by the collision scenario.
        clear        = 1'b1;
        sample_in    = 8'hFF;
        sample_valid = 1'b1;
        step();
        clear        = 1'b0;
        sample_valid = 1'b0;
        sample_in    = 8'h00;
        tb_phase     = 0;
        total++; if (cur_value !== 8'h00) begin bad++; $display("FAIL clr_cur got=%h exp=00", cur_value); end
        total++; if (peak_value !== 8'h00) begin bad++; $display("FAIL clr_peak got=%h exp=00", peak_value); end
        total++; if (state_o !== 2'b00) begin bad++; $display("FAIL clr_state got=%b exp=00", state_o); end
    endtask

    task automatic test_peak();
        // Tick alignment here relies on clear having zeroed the timebase.
        send(8'h10);
        tick_step();
        total++; if (state_o !== 2'b01) begin bad++; $display("FAIL pk_hold got=%b exp=01", state_o); end
        tick_step();
        total++; if (state_o !== 2'b10) begin bad++; $display("FAIL pk_decay got=%b exp=10", state_o); end
        run_to_idle("pk10");
        total++; if (peak_value !== 8'h10) begin bad++; $display("FAIL pk_10 got=%h exp=10", peak_value); end
        send(8'h80);
        total++; if (peak_value !== 8'h80) begin bad++; $display("FAIL pk_80 got=%h exp=80", peak_value); end
        run_to_idle("pk80");
        send(8'h20);
        total++; if (cur_value !== 8'h20) begin bad++; $display("FAIL pk_20_cur got=%h exp=20", cur_value); end
        total++; if (peak_value !== 8'h80) begin bad++; $display("FAIL pk_20_peak got=%h exp=80", peak_value); end
        run_to_idle("pk20");
        total++; if (peak_value !== 8'h80) begin bad++; $display("FAIL pk_final got=%h exp=80", peak_value); end
        total++; if (cur_value !== 8'h00) begin bad++; $display("FAIL pk_final_cur got=%h exp=00", cur_value); end
    endtask

    initial begin
        test_reset();
        test_attack_decay();
        test_ignore_restart();
        test_collision();
        test_clear();
        test_peak();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
